sdram_burst_sched: RTL and testbench

Single-clock burst scheduler between the write/read FIFOs and the SDRAM command engine. Monitors FIFO occupancy, a refresh request and the amount of data buffered in SDRAM, and issues one burst command at a time: refresh, write burst (write FIFO to SDRAM) or read burst (SDRAM to read FIFO). Maintains circular SDRAM write/read address pointers over a fixed region, making the SDRAM behave as a large FIFO.

---
 rtl/sdram_burst_sched.sv | 159 +++++++++++++++
 tb/tb_sdram_burst_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_sched.sv
// Burst scheduler: arbitrates refresh / write-burst / read-burst commands to the SDRAM engine
// and keeps circular write/read pointers so the SDRAM region behaves as a FIFO. Optional: SDRAM_SCHED_RR_EN.
module sdram_burst_sched #(
  parameter int ADDR_W       = 24,
  parameter int USE_W        = 10,
  parameter int FIFO_DEPTH   = 512,
  parameter int BURST_LEN    = 8,
  parameter int REGION_BASE  = 0,
  parameter int REGION_WORDS = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_init_done,
  input  logic              i_ref_req,
  output logic              o_ref_ack,
  input  logic [USE_W-1:0]  i_wr_use,
  input  logic [USE_W-1:0]  i_rd_use,
  output logic              o_cmd_valid,
  output logic [1:0]        o_cmd_type,
  output logic [ADDR_W-1:0] o_cmd_addr,
  input  logic              i_cmd_ready,
  input  logic              i_cmd_done,
  output logic [ADDR_W:0]   o_level,
  output logic              o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_REQ, S_WAIT} state_t;

  localparam logic [1:0]        T_WR    = 2'b00;
  localparam logic [1:0]        T_RD    = 2'b01;
  localparam logic [1:0]        T_REF   = 2'b10;
  localparam logic [ADDR_W:0]   BL_L    = (ADDR_W+1)'(BURST_LEN);
  localparam logic [ADDR_W:0]   LVL_MAX = (ADDR_W+1)'(REGION_WORDS - BURST_LEN);
  localparam logic [ADDR_W:0]   REG_END = (ADDR_W+1)'(REGION_WORDS);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(REGION_BASE);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          w_sel;
  logic                w_decide;
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic                r_cmd_valid;
  logic [1:0]          r_cmd_type;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic                r_ref_ack;
  logic                r_busy;
  logic [ADDR_W:0]     r_level;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
`ifdef SDRAM_SCHED_RR_EN
  logic                r_last_rd;
`endif

  // Pointer advance; REGION_WORDS is a burst multiple, so the sum lands exactly on the end.
  function automatic logic [ADDR_W-1:0] f_ptr_next(input logic [ADDR_W-1:0] p);
    logic [ADDR_W:0] s;
    s = {1'b0, p} + BL_L;
    if (s >= REG_END) s = '0;
    return s[ADDR_W-1:0];
  endfunction

  assign w_wr_ok = (32'(i_wr_use) >= 32'(BURST_LEN)) && (r_level <= LVL_MAX);
  assign w_rd_ok = (r_level >= BL_L) &&
                   (32'(i_rd_use) + 32'(BURST_LEN) <= 32'(FIFO_DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_sel    = T_WR;
    w_decide = 1'b0;
    case (r_state)
      S_IDLE: if (i_init_done) w_next = S_ARB;
      S_ARB: begin
        if (i_ref_req) begin
          w_sel    = T_REF;
          w_decide = 1'b1;
        end else if (w_wr_ok && w_rd_ok) begin
`ifdef SDRAM_SCHED_RR_EN
          w_sel    = r_last_rd ? T_WR : T_RD;
`else
          w_sel    = T_WR;
`endif
          w_decide = 1'b1;
        end else if (w_wr_ok) begin
          w_sel    = T_WR;
          w_decide = 1'b1;
        end else if (w_rd_ok) begin
          w_sel    = T_RD;
          w_decide = 1'b1;
        end
        if (w_decide) w_next = S_REQ;
      end
      S_REQ:  if (i_cmd_ready) w_next = S_WAIT;
      S_WAIT: if (i_cmd_done) w_next = S_ARB;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= T_WR;
      r_cmd_addr  <= BASE_A;
      r_ref_ack   <= 1'b0;
      r_busy      <= 1'b0;
      r_level     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
`ifdef SDRAM_SCHED_RR_EN
      r_last_rd   <= 1'b1;
`endif
    end else begin
      r_ref_ack <= 1'b0;
      r_busy    <= (w_next == S_REQ) || (w_next == S_WAIT);
      case (r_state)
        S_ARB: if (w_decide) begin
          r_cmd_valid <= 1'b1;
          r_cmd_type  <= w_sel;
          if (w_sel == T_WR)      r_cmd_addr <= BASE_A + r_wr_ptr;
          else if (w_sel == T_RD) r_cmd_addr <= BASE_A + r_rd_ptr;
          else                    r_cmd_addr <= BASE_A;
        end
        S_REQ: if (i_cmd_ready) r_cmd_valid <= 1'b0;
        // Completion bookkeeping: only one command is ever outstanding.
        S_WAIT: if (i_cmd_done) begin
          if (r_cmd_type == T_WR) begin
            r_wr_ptr  <= f_ptr_next(r_wr_ptr);
            r_level   <= r_level + BL_L;
`ifdef SDRAM_SCHED_RR_EN
            r_last_rd <= 1'b0;
`endif
          end else if (r_cmd_type == T_RD) begin
            r_rd_ptr  <= f_ptr_next(r_rd_ptr);
            r_level   <= r_level - BL_L;
`ifdef SDRAM_SCHED_RR_EN
            r_last_rd <= 1'b1;
`endif
          end else begin
            r_ref_ack <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_type  = r_cmd_type;
  assign o_cmd_addr  = r_cmd_addr;
  assign o_ref_ack   = r_ref_ack;
  assign o_level     = r_level;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Scoreboard bench for sdram_burst_sched: a queue of expected commands from a level/pointer model,
// a negedge monitor that pops on each new command, and a driver emulating the SDRAM command engine.
module tb_sdram_burst_sched;
  localparam int ADDR_W = 24, USE_W = 10, FIFO_DEPTH = 512, BL = 8, BASE = 0, RW = 1024;

  logic              clk = 1'b0;
  logic              rst, init_done, ref_req, ref_ack, cmd_valid, cmd_ready, cmd_done, busy;
  logic [USE_W-1:0]  wr_use, rd_use;
  logic [1:0]        cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   level;

  always #5 clk = ~clk;

  sdram_burst_sched #(.ADDR_W(ADDR_W), .USE_W(USE_W), .FIFO_DEPTH(FIFO_DEPTH), .BURST_LEN(BL),
                      .REGION_BASE(BASE), .REGION_WORDS(RW)) dut (
    .i_clk(clk), .i_rst(rst), .i_init_done(init_done), .i_ref_req(ref_req), .o_ref_ack(ref_ack),
    .i_wr_use(wr_use), .i_rd_use(rd_use), .o_cmd_valid(cmd_valid), .o_cmd_type(cmd_type),
    .o_cmd_addr(cmd_addr), .i_cmd_ready(cmd_ready), .i_cmd_done(cmd_done), .o_level(level),
    .o_busy(busy));

  typedef struct { int t; int a; } cmd_t;
  cmd_t q[$];

  int checks = 0, errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: SDRAM viewed as a FIFO of bursts over a circular region.
  int m_level, m_wr, m_rd;
  bit m_last_rd, m_ref;

  task automatic model_reset();
    m_level = 0; m_wr = 0; m_rd = 0; m_last_rd = 1'b1; m_ref = 1'b0;
  endtask

  task automatic model_done(input int t);
    if (t == 0) begin
      m_wr = (m_wr + BL) % RW; m_level += BL; m_last_rd = 1'b0;
    end else if (t == 1) begin
      m_rd = (m_rd + BL) % RW; m_level -= BL; m_last_rd = 1'b1;
    end else begin
      m_ref = 1'b0;
    end
  endtask

  function automatic int predict(input int wu, input int ru, input bit rf, output int ea);
    bit wr_ok, rd_ok;
    wr_ok = (wu >= BL) && (m_level + BL <= RW);
    rd_ok = (m_level >= BL) && (FIFO_DEPTH - ru >= BL);
    ea = BASE;
    if (rf) return 2;
    if (wr_ok && rd_ok) begin
`ifdef SDRAM_SCHED_RR_EN
      if (!m_last_rd) begin ea = BASE + m_rd; return 1; end
`endif
      ea = BASE + m_wr;
      return 0;
    end
    if (wr_ok) begin ea = BASE + m_wr; return 0; end
    if (rd_ok) begin ea = BASE + m_rd; return 1; end
    return -1;
  endfunction

  // Monitor: every rising o_cmd_valid must match the oldest expected command.
  bit   prev_v = 1'b0;
  cmd_t mon_e;
  always @(negedge clk) begin
    if (rst) prev_v = 1'b0;
    else begin
      if (cmd_valid && !prev_v) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd: got type %0d addr %0d expected none", cmd_type, cmd_addr);
        end else begin
          mon_e = q.pop_front();
          check("cmd_type", cmd_type, mon_e.t);
          check("cmd_addr", cmd_addr, mon_e.a);
        end
      end else if (cmd_valid) begin
        check("cmd_type_hold", cmd_type, mon_e.t);
        check("cmd_addr_hold", cmd_addr, mon_e.a);
      end
      prev_v = cmd_valid;
    end
  end

  bit outstanding = 1'b0, first = 1'b0, in_arb = 1'b0;
  int last_t = 0;

  task automatic wait_valid(inout int lat);
    while (!cmd_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!cmd_valid) begin
      $display("FAIL cmd_timeout: got no command expected one");
      $fatal(1, "engine wait expired");
    end
  endtask

  task automatic step(input int wu, input int ru, input bit rf);
    int et, ea, lat, exp_lat;
    bit done_ref;
    cmd_t c;
    @(negedge clk);
    wr_use = USE_W'(wu);
    rd_use = USE_W'(ru);
    if (rf && !(outstanding && last_t == 2)) begin ref_req = 1'b1; m_ref = 1'b1; end
    if (first) init_done = 1'b1;
    done_ref = 1'b0;
    if (outstanding) begin
      cmd_done = 1'b1;
      model_done(last_t);
      done_ref = (last_t == 2);
    end
    et = predict(wu, ru, m_ref, ea);
    exp_lat = (outstanding || first) ? 2 : 1;
    lat = 0;
    if (outstanding || first) begin
      @(negedge clk);
      lat = 1;
      cmd_done = 1'b0;
      if (outstanding) begin
        check("level_after_done", level, m_level);
        check("ref_ack", ref_ack, done_ref);
        check("busy_in_arb", busy, 0);
        if (done_ref) ref_req = 1'b0;
      end else begin
        check("valid_not_yet", cmd_valid, 0);
      end
    end
    first = 1'b0;
    outstanding = 1'b0;
    if (et < 0) begin
      repeat (6) @(negedge clk);
      check("no_cmd_when_ineligible", cmd_valid, 0);
      in_arb = 1'b1;
      return;
    end
    c.t = et; c.a = ea;
    q.push_back(c);
    wait_valid(lat);
    check("cmd_latency", lat, exp_lat);
    check("busy_req", busy, 1);
    in_arb = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("valid_drop", cmd_valid, 0);
    check("busy_wait", busy, 1);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    outstanding = 1'b1;
    last_t = et;
  endtask

  initial begin
    int wu, ru, et, ea, lat;
    cmd_t c;
    rst = 1'b1; init_done = 1'b0; ref_req = 1'b0; wr_use = '0; rd_use = '0;
    cmd_ready = 1'b0; cmd_done = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", cmd_valid, 0);
    check("rst_type", cmd_type, 0);
    check("rst_addr", cmd_addr, BASE);
    check("rst_ack", ref_ack, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_wo_init", cmd_valid, 0);

    first = 1'b1;
    step(8, 0, 0);
    for (int i = 0; i < 127; i++) step(512, 512, 0);
    step(512, 512, 0);
    check("level_full", level, RW);
    step(512, 505, 0);
    step(512, 504, 0);
    step(512, 512, 0);

    for (int i = 0; i < 126; i++) step(0, 0, 0);
    step(0, 505, 0);
    check("level_16", level, 16);
    step(0, 504, 0);
    step(8, 512, 1);
    step(8, 512, 0);
    for (int i = 0; i < 8; i++) step(512, 0, 0);

    init_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 2))
        0: wu = $urandom_range(0, 7);
        1: wu = 8;
        default: wu = $urandom_range(9, 512);
      endcase
      case ($urandom_range(0, 2))
        0: ru = $urandom_range(505, 512);
        1: ru = 504;
        default: ru = $urandom_range(0, 503);
      endcase
      step(wu, ru, ($urandom_range(0, 9) == 0));
    end

    // Reset while a command is presented and not accepted.
    @(negedge clk);
    wr_use = USE_W'(512); rd_use = '0;
    if (outstanding) begin cmd_done = 1'b1; model_done(last_t); end
    et = predict(512, 0, m_ref, ea);
    c.t = et; c.a = ea;
    q.push_back(c);
    @(negedge clk);
    cmd_done = 1'b0;
    if (outstanding && last_t == 2) ref_req = 1'b0;
    outstanding = 1'b0;
    lat = 1;
    wait_valid(lat);
    repeat (2) @(negedge clk);
    rst = 1'b1; init_done = 1'b0; ref_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", cmd_valid, 0);
    check("midrst_level", level, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ack", ref_ack, 0);
    model_reset();
    q.delete();
    repeat (4) @(negedge clk);
    check("midrst_idle", cmd_valid, 0);
    first = 1'b1;
    step(8, 0, 0);
    step(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "time limit");
  end

endmodule
